// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Pipeline WB stage; picks RAM load data or the ALU result for
//               the register file write port, registered on write cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int DATA_WIDTH = 32,
  parameter bit OUT_REG    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  iSig_regfile_write,
  input  logic                  iSig_MemtoReg,
  input  logic [DATA_WIDTH-1:0] iread_from_ram,
  input  logic [DATA_WIDTH-1:0] ialu_result,
  output logic [DATA_WIDTH-1:0] odata2write2regfile
);

  logic [DATA_WIDTH-1:0] w_sel_data;

  // A ternary keeps an undriven unselected input from reaching the output.
  assign w_sel_data = iSig_MemtoReg ? iread_from_ram : ialu_result;

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] r_wb_data;

      // rstn is active-high here; it takes priority over any control input.
      always_ff @(posedge clk) begin
        if (rstn) begin
          r_wb_data <= '0;
        end else if (iSig_regfile_write) begin
          r_wb_data <= w_sel_data;
        end
      end

      assign odata2write2regfile = r_wb_data;
    end else begin : g_out_comb
      logic w_unused_ok;
      assign w_unused_ok         = &{1'b0, clk, rstn, iSig_regfile_write};
      assign odata2write2regfile = w_sel_data;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Self-checking scoreboard bench for writeback_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  localparam int c_dw = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic            wr;
  logic            m2r;
  logic [c_dw-1:0] ram;
  logic [c_dw-1:0] alu;
  logic [c_dw-1:0] out;

  logic [c_dw-1:0] sb[$];
  logic [c_dw-1:0] model_q;
  logic [c_dw-1:0] exp_v;
  int              n_checks = 0;
  int              n_fail   = 0;

  writeback_stage #(.DATA_WIDTH(c_dw), .OUT_REG(1'b1)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .iSig_regfile_write  (wr),
    .iSig_MemtoReg       (m2r),
    .iread_from_ram      (ram),
    .ialu_result         (alu),
    .odata2write2regfile (out)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and queue the value expected after the edge.
  task automatic apply(input logic r, input logic w, input logic m,
                       input logic [c_dw-1:0] rd, input logic [c_dw-1:0] al);
    rstn = r; wr = w; m2r = m; ram = rd; alu = al;
    if (r === 1'b1)      model_q = '0;
    else if (w === 1'b1) model_q = (m === 1'b1) ? rd : al;
    sb.push_back(model_q);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (out !== exp_v) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected %h", i, out, exp_v);
      end
    end
  endtask

  task automatic test_alu_write();
    apply(1'b0, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'h0000_1234);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_checks++;
    if (out !== exp_v || out !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL alu_write: got %h expected %h", out, exp_v);
    end
  endtask

  task automatic test_ram_write();
    apply(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_checks++;
    if (out !== exp_v || out !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL ram_write: got %h expected %h", out, exp_v);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'(i), 32'h1111_0000 + i, 32'h2222_0000 + i);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (out !== exp_v || out !== 32'hDEAD_BEEF) begin
        n_fail++;
        $display("FAIL hold[%0d]: got %h expected %h", i, out, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b0, 1'b1, 1'b0, 32'h0000_0009, 32'h0000_0005);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_checks++;
    if (out !== exp_v || out !== 32'h5) begin
      n_fail++;
      $display("FAIL b2b_alu: got %h expected %h", out, exp_v);
    end
    apply(1'b0, 1'b1, 1'b1, 32'h0000_0007, 32'h0000_0003);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_checks++;
    if (out !== exp_v || out !== 32'h7) begin
      n_fail++;
      $display("FAIL b2b_ram: got %h expected %h", out, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    apply(1'b1, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_checks++;
    if (out !== exp_v || out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected %h", out, exp_v);
    end
    apply(1'b0, 1'b1, 1'b0, 32'h0, 32'h0BAD_F00D);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_checks++;
    if (out !== exp_v || out !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL after_reset: got %h expected %h", out, exp_v);
    end
  endtask

  // Full-width values must pass unchanged; unselected inputs may be undriven.
  task automatic test_width_and_x();
    apply(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hxxxx_xxxx);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_checks++;
    if (out !== exp_v) begin
      n_fail++;
      $display("FAIL width_ram: got %h expected %h", out, exp_v);
    end
    apply(1'b0, 1'b1, 1'b0, 32'hxxxx_xxxx, 32'hFFFF_0080);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    n_checks++;
    if (out !== exp_v) begin
      n_fail++;
      $display("FAIL width_alu: got %h expected %h", out, exp_v);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      apply(($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom), $urandom, $urandom);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_checks++;
      if (out !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", i, out, exp_v);
      end
    end
  endtask

  initial begin
    model_q = '0;
    rstn = 1'b1; wr = 1'b0; m2r = 1'b0; ram = '0; alu = '0;
    @(posedge clk); #1;
    test_reset();
    test_alu_write();
    test_ram_write();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_width_and_x();
    test_random();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
